// File: rtl/rangefinder_sample_capture.sv
// Rangefinder echo capture: arm, wait for laser trigger, delay,
// then write DEPTH decimated ADC samples into the sample RAM.
module rangefinder_sample_capture #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int DELAY_W = 16,
  parameter int DECIM_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              trig_in,
  input  logic              arm,
  input  logic              abort,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [DECIM_W-1:0] cfg_decim,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_write,
  output logic              ram_chipselect,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TRIG,
    DELAY,
    CAPTURE,
    DONE
  } state_t;

  state_t state, state_nx;

  logic               trig_q;
  logic               trig_edge;
  logic               arm_ok;
  logic               accept;
  logic               at_limit;
  logic               last_write;
  logic [DELAY_W-1:0] delay_cfg;
  logic [DELAY_W-1:0] delay_cnt;
  logic [DECIM_W-1:0] decim_cfg;
  logic [DECIM_W-1:0] decim_cnt;
  logic               write_q;
  logic [DATA_W-1:0]  data_q;
  logic [ADDR_W:0]    count;
  logic [ADDR_W+1:0]  filled;

  assign trig_edge = trig_in & ~trig_q;
  assign arm_ok = arm & ~abort
                & ((state == IDLE) | (state == DONE));

  // A write still in flight counts toward the record length
  assign filled = {1'b0, count}
                + {{(ADDR_W+1){1'b0}}, write_q};
  assign at_limit = filled >= (ADDR_W+2)'(DEPTH);
  assign last_write = write_q
                    & (count == (ADDR_W+1)'(DEPTH-1));

  assign accept = (state == CAPTURE) & adc_valid
                & (decim_cnt == '0) & ~at_limit & ~abort;

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (arm) state_nx = WAIT_TRIG;
        end
        WAIT_TRIG: begin
          if (trig_edge)
            state_nx = (delay_cfg == '0) ? CAPTURE : DELAY;
        end
        DELAY: begin
          if (delay_cnt == DELAY_W'(1)) state_nx = CAPTURE;
        end
        CAPTURE: begin
          if (last_write) state_nx = DONE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      trig_q    <= 1'b0;
      delay_cfg <= '0;
      delay_cnt <= '0;
      decim_cfg <= '0;
      decim_cnt <= '0;
      write_q   <= 1'b0;
      data_q    <= '0;
      count     <= '0;
    end else begin
      state   <= state_nx;
      trig_q  <= trig_in;
      write_q <= accept;
      if (accept) data_q <= adc_data;
      if (write_q) count <= count + (ADDR_W+1)'(1);

      if (state == WAIT_TRIG && trig_edge)
        delay_cnt <= delay_cfg;
      else if (state == DELAY)
        delay_cnt <= delay_cnt - DELAY_W'(1);

      if (state == CAPTURE && adc_valid) begin
        if (decim_cnt == '0) decim_cnt <= decim_cfg;
        else decim_cnt <= decim_cnt - DECIM_W'(1);
      end

      if (arm_ok) begin
        delay_cfg <= cfg_delay;
        decim_cfg <= cfg_decim;
        decim_cnt <= '0;
        count     <= '0;
      end
    end
  end

  assign ram_address    = count[ADDR_W-1:0];
  assign ram_writedata  = data_q;
  assign ram_write      = write_q;
  assign ram_chipselect = write_q;
  assign busy = (state == WAIT_TRIG) | (state == DELAY)
              | (state == CAPTURE);
  assign done = (state == DONE);
  assign wr_count = count;

endmodule

// File: tb/tb_rangefinder_sample_capture.sv
// Bench for rangefinder_sample_capture: random stimulus against
// a record-level model of the capture sequence.
module tb_rangefinder_sample_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        trig_in = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_delay = '0;
  logic [7:0]  cfg_decim = '0;
  logic [7:0]  ram_address;
  logic [7:0]  ram_writedata;
  logic        ram_write;
  logic        ram_chipselect;
  logic        busy;
  logic        done;
  logic [8:0]  wr_count;

  rangefinder_sample_capture dut (
    .clk(clk),
    .reset_n(reset_n),
    .adc_data(adc_data),
    .adc_valid(adc_valid),
    .trig_in(trig_in),
    .arm(arm),
    .abort(abort),
    .cfg_delay(cfg_delay),
    .cfg_decim(cfg_decim),
    .ram_address(ram_address),
    .ram_writedata(ram_writedata),
    .ram_write(ram_write),
    .ram_chipselect(ram_chipselect),
    .busy(busy),
    .done(done),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tcyc = 0;

  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Record-level model: a record is active from arm until the
  // last write; capture opens delay+1 cycles after the trigger
  // edge and keeps every (decim+1)-th valid sample from there.
  int m_cyc = 0;
  bit m_act = 0;
  bit m_done = 0;
  bit m_trg = 0;
  int m_cap = 0;
  int m_nval = 0;
  int m_cnt = 0;
  int m_dly = 0;
  int m_dec = 0;
  bit m_tprev = 0;
  bit e_wr = 0;
  int e_data = 0;
  bit s_edge, s_cap, s_nw;
  int s_nd;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_act = 0; m_done = 0; m_trg = 0;
      m_cnt = 0; m_nval = 0; m_tprev = 0;
      e_wr = 0; e_data = 0;
    end else begin
      s_edge = trig_in && !m_tprev;
      m_tprev = trig_in;
      s_cap = m_act && m_trg && (m_cyc >= m_cap);
      s_nw = 0;
      s_nd = 0;
      if (s_cap && adc_valid && !abort
          && (m_cnt + int'(e_wr)) < 256) begin
        if (m_nval % (m_dec + 1) == 0) begin
          s_nw = 1;
          s_nd = int'(adc_data);
        end
        m_nval++;
      end
      if (e_wr) m_cnt++;
      if (m_act && m_cnt == 256) begin
        m_act = 0;
        m_done = 1;
      end
      if (m_act && !m_trg && s_edge) begin
        m_trg = 1;
        m_cap = m_cyc + 1 + m_dly;
      end
      if (abort) begin
        m_act = 0;
        m_done = 0;
        s_nw = 0;
      end else if (arm && !m_act) begin
        m_act = 1; m_done = 0; m_cnt = 0;
        m_trg = 0; m_nval = 0;
        m_dly = int'(cfg_delay);
        m_dec = int'(cfg_decim);
      end
      e_wr = s_nw;
      e_data = s_nd;
      m_cyc++;
    end
  end

  int log_addr[$];
  int log_data[$];
  int log_cyc[$];

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      chk("ram_write", ram_write, e_wr);
      chk("ram_chipselect", ram_chipselect, e_wr);
      chk("busy", busy, m_act);
      chk("done", done, m_done);
      chk("wr_count", wr_count, m_cnt);
      if (e_wr) begin
        chk("ram_address", ram_address, m_cnt % 256);
        chk("ram_writedata", ram_writedata, e_data);
      end
    end
    if (ram_write) begin
      log_addr.push_back(int'(ram_address));
      log_data.push_back(int'(ram_writedata));
      log_cyc.push_back(tcyc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int vpct, bit rtrig);
    adc_valid = ($urandom_range(99) < vpct);
    adc_data = 8'($urandom);
    if (rtrig) trig_in = 1'($urandom);
  endtask

  task automatic do_arm(int d, int dc);
    cfg_delay = 16'(d);
    cfg_decim = 8'(dc);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    cfg_delay = 16'($urandom);
    cfg_decim = 8'($urandom);
  endtask

  task automatic fire;
    trig_in = 1'b0;
    tick();
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
  endtask

  task automatic run(int n, int vpct, bit rtrig);
    for (int i = 0; i < n; i++) begin
      drive(vpct, rtrig);
      tick();
    end
    adc_valid = 1'b0;
  endtask

  task automatic run_until(int base, int target, int vpct,
                           bit rtrig, int budget);
    int k;
    k = 0;
    while (log_addr.size() - base < target && k < budget) begin
      drive(vpct, rtrig);
      tick();
      k++;
    end
    adc_valid = 1'b0;
    if (log_addr.size() - base < target) begin
      checks++;
      errors++;
      $display("FAIL run_until: got %0d writes expected %0d",
               log_addr.size() - base, target);
    end
  endtask

  int b, b2, e, n;
  bit ok;

  initial begin
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // 1: reset state, trigger/valid activity while idle
    chk("t1_write", ram_write, 0);
    chk("t1_cs", ram_chipselect, 0);
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 0);
    chk("t1_count", wr_count, 0);
    chk("t1_addr", ram_address, 0);
    chk("t1_data", ram_writedata, 0);
    b = log_addr.size();
    run(12, 60, 1'b1);
    trig_in = 1'b0;
    chk("t1_idle_writes", log_addr.size() - b, 0);

    // arm together with abort: abort wins
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    chk("arm_abort_busy", busy, 0);

    // 2: no delay, no decimation, data = index
    do_arm(0, 0);
    fire();
    b = log_addr.size();
    for (int k = 0; k < 256; k++) begin
      adc_valid = 1'b1;
      adc_data = 8'(k);
      tick();
    end
    adc_valid = 1'b0;
    repeat (3) tick();
    chk("t2_writes", log_addr.size() - b, 256);
    ok = 1;
    if (log_addr.size() - b >= 256)
      for (int i = 0; i < 256; i++)
        if (log_addr[b+i] != i || log_data[b+i] != i) ok = 0;
    chk("t2_seq", ok, 1);
    chk("t2_done", done, 1);
    chk("t2_count", wr_count, 256);
    chk("t2_busy", busy, 0);

    // 3: delay 10, decimate by 3, valid every cycle
    do_arm(10, 2);
    trig_in = 1'b0;
    tick();
    trig_in = 1'b1;
    adc_valid = 1'b1;
    tick();
    e = tcyc;
    trig_in = 1'b0;
    b = log_addr.size();
    run(11 + 3 * 256 + 4, 100, 1'b0);
    repeat (2) tick();
    chk("t3_writes", log_addr.size() - b, 256);
    if (log_addr.size() - b >= 256) begin
      chk("t3_first_cyc", log_cyc[b] - e, 11);
      chk("t3_last_cyc", log_cyc[b+255] - e, 11 + 255 * 3);
    end
    chk("t3_done", done, 1);

    // 4: abort after 100 writes, then re-arm
    do_arm($urandom_range(5), $urandom_range(3));
    fire();
    b = log_addr.size();
    run_until(b, 100, 70, 1'b0, 5000);
    abort = 1'b1;
    drive(70, 1'b0);
    tick();
    abort = 1'b0;
    n = log_addr.size() - b;
    run(20, 70, 1'b1);
    trig_in = 1'b0;
    chk("t4_writes_range", int'(n == 100 || n == 101), 1);
    chk("t4_no_more", log_addr.size() - b, n);
    chk("t4_count_range",
        int'(wr_count == 9'd100 || wr_count == 9'd101), 1);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    do_arm(0, 0);
    chk("t4_rearm_count", wr_count, 0);
    b2 = log_addr.size();
    fire();
    run(10, 100, 1'b0);
    chk("t4_rearm_wr", int'(log_addr.size() > b2), 1);
    if (log_addr.size() > b2)
      chk("t4_rearm_addr", log_addr[b2], 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // 5: extra trigger edge and arm while busy
    do_arm($urandom_range(7), 1);
    fire();
    b = log_addr.size();
    run_until(b, 50, 80, 1'b0, 3000);
    trig_in = 1'b0;
    tick();
    trig_in = 1'b1;
    arm = 1'b1;
    cfg_delay = 16'd3;
    cfg_decim = 8'd0;
    tick();
    arm = 1'b0;
    run_until(b, 256, 80, 1'b1, 3000);
    trig_in = 1'b0;
    repeat (3) tick();
    chk("t5_writes", log_addr.size() - b, 256);
    ok = 1;
    if (log_addr.size() - b >= 256)
      for (int i = 0; i < 256; i++)
        if (log_addr[b+i] != i) ok = 0;
    chk("t5_seq", ok, 1);
    chk("t5_done", done, 1);

    // 6: asynchronous reset mid-capture
    do_arm(2, 0);
    fire();
    b = log_addr.size();
    run_until(b, 30, 100, 1'b0, 1000);
    adc_valid = 1'b1;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_write", ram_write, 0);
    chk("t6_cs", ram_chipselect, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_count", wr_count, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    b = log_addr.size();
    run(20, 100, 1'b1);
    trig_in = 1'b0;
    chk("t6_no_writes", log_addr.size() - b, 0);
    chk("t6_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
